// File: rtl/key_event_encoder.sv
// Pushbutton event encoder: synchronizer, debouncer, press/auto-repeat detection
// and a small event FIFO that carries {is_repeat, keycode} entries to the reader.
module key_event_encoder #(
  parameter int NKEYS      = 13,
  parameter int CODEW      = 4,
  parameter int DB_CYCLES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int RPT_DELAY  = 0,
  parameter int RPT_RATE   = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [NKEYS-1:0] keypad,
  input  logic             rd_en,
  input  logic             ovf_clr,
  output logic [CODEW-1:0] keycode,
  output logic             is_repeat,
  output logic             valid,
  output logic             keystrobe,
  output logic             overflow
);

  localparam int DBW  = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam int PW   = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RW   = (RMAX < 2) ? 1 : $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  logic [NKEYS-1:0] sync1_q, sync2_q, smp_q, deb_q, deb_d, rise;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             press_ev, rpt_ev, ev, trk_held;
  logic [CODEW-1:0] press_code, ev_code;
  logic             ev_rpt;

  rpt_state_e       state_q;
  logic [CODEW-1:0] trk_q;
  logic [RW-1:0]    rcnt_q;

  logic [CODEW:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             full, do_push, do_pop, drop;
  logic             keystrobe_q, overflow_q;

  // smp_q holds last cycle's synchronized vector so any change restarts the count.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q != smp_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DBW'(DB_CYCLES)) begin
      deb_d = sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rise       = deb_d & ~deb_q;
    press_ev   = |rise;
    press_code = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (rise[i]) press_code = CODEW'(i);
    end
  end

  always_comb begin
    trk_held = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (trk_q == CODEW'(i)) trk_held = deb_q[i];
    end
  end

  // A fresh press always wins over a repeat falling due in the same cycle.
  always_comb begin
    rpt_ev = 1'b0;
    if ((RPT_DELAY != 0) && !press_ev && trk_held) begin
      if (state_q == ST_HOLD && rcnt_q == RW'(RPT_DELAY - 1)) rpt_ev = 1'b1;
      if (state_q == ST_RPT  && rcnt_q == RW'(RPT_RATE - 1))  rpt_ev = 1'b1;
    end
  end

  assign ev      = press_ev | rpt_ev;
  assign ev_rpt  = ~press_ev;
  assign ev_code = press_ev ? press_code : trk_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      smp_q    <= '0;
      deb_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= keypad;
      sync2_q  <= sync1_q;
      smp_q    <= sync2_q;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      trk_q   <= '0;
      rcnt_q  <= '0;
    end else if (RPT_DELAY != 0) begin
      if (press_ev) begin
        state_q <= ST_HOLD;
        trk_q   <= press_code;
        rcnt_q  <= '0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (!trk_held) begin
              state_q <= ST_IDLE;
            end else if (rpt_ev) begin
              state_q <= ST_RPT;
              rcnt_q  <= '0;
            end else begin
              rcnt_q  <= rcnt_q + 1'b1;
            end
          end
          ST_RPT: begin
            if (!trk_held) begin
              state_q <= ST_IDLE;
            end else if (rpt_ev) begin
              rcnt_q  <= '0;
            end else begin
              rcnt_q  <= rcnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
  always_comb begin
    full    = (count_q == (PW+1)'(FIFO_DEPTH));
    do_pop  = rd_en & (count_q != '0);
    do_push = ev & (~full | do_pop);
    drop    = ev & full & ~do_pop;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {ev_rpt, ev_code};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      keystrobe_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      keystrobe_q <= ev;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_comb begin
    valid     = (count_q != '0);
    keycode   = valid ? mem_q[rd_ptr_q][CODEW-1:0] : '0;
    is_repeat = valid ? mem_q[rd_ptr_q][CODEW] : 1'b0;
  end

  assign keystrobe = keystrobe_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: dut0 uses defaults (no repeat), dut1 enables auto-repeat.
// Expected {is_repeat, code} entries are queued by stimulus and checked by monitors on pops.
module tb_key_event_encoder;
  localparam int NK = 13;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [NK-1:0] keypad0, keypad1;
  logic          rd_en0, rd_en1, ovf_clr0, ovf_clr1;
  logic [CW-1:0] keycode0, keycode1;
  logic          is_repeat0, is_repeat1, valid0, valid1;
  logic          keystrobe0, keystrobe1, overflow0, overflow1;

  key_event_encoder dut0 (
    .clk(clk), .nrst(nrst), .keypad(keypad0), .rd_en(rd_en0), .ovf_clr(ovf_clr0),
    .keycode(keycode0), .is_repeat(is_repeat0), .valid(valid0),
    .keystrobe(keystrobe0), .overflow(overflow0)
  );

  key_event_encoder #(.RPT_DELAY(10), .RPT_RATE(4)) dut1 (
    .clk(clk), .nrst(nrst), .keypad(keypad1), .rd_en(rd_en1), .ovf_clr(ovf_clr1),
    .keycode(keycode1), .is_repeat(is_repeat1), .valid(valid1),
    .keystrobe(keystrobe1), .overflow(overflow1)
  );

  logic [CW:0] exp_q[$];
  logic [CW:0] exp1_q[$];
  int          exp_t_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_stb0 = 0;
  int          n_stb1 = 0;
  int          cyc = 0;
  int          base;
  int          m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press0(input int k, input bit expect_stored);
    keypad0 = 13'd1 << k;
    if (expect_stored) exp_q.push_back({1'b0, CW'(k)});
    ticks(10);
  endtask

  // dut0 monitor: count strobes, compare the head on every accepted pop.
  always @(negedge clk) begin
    if (keystrobe0) n_stb0++;
    if (rd_en0 && valid0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop0_unexpected: got %0h, expected nothing", {is_repeat0, keycode0});
      end else begin
        check("pop0", {is_repeat0, keycode0}, exp_q.pop_front());
      end
    end
  end

  // dut1 monitor: strobe timing against expected cycles, plus popped entries.
  always @(negedge clk) begin
    if (keystrobe1) begin
      n_stb1++;
      if (exp_t_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL strobe1_unexpected: got strobe at cycle %0d, expected none", cyc);
      end else begin
        check("strobe1_time", cyc, exp_t_q.pop_front());
      end
    end
    if (rd_en1 && valid1) begin
      if (exp1_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop1_unexpected: got %0h, expected nothing", {is_repeat1, keycode1});
      end else begin
        check("pop1", {is_repeat1, keycode1}, exp1_q.pop_front());
      end
    end
  end

  initial begin
    keypad0 = '0; keypad1 = '0;
    rd_en0 = 1'b0; rd_en1 = 1'b1;
    ovf_clr0 = 1'b0; ovf_clr1 = 1'b0;
    ticks(3);
    check("rst_valid", valid0, 0);
    check("rst_keycode", keycode0, 0);
    check("rst_overflow", overflow0, 0);
    check("rst_keystrobe", keystrobe0, 0);
    check("rst_valid1", valid1, 0);
    nrst = 1'b1;
    ticks(10);

    // single press: strobe exactly at N+7
    keypad0 = 13'h0020;
    exp_q.push_back({1'b0, 4'd5});
    ticks(7);
    check("press_early", keystrobe0, 0);
    tick();
    check("press_strobe", keystrobe0, 1);
    check("press_valid", valid0, 1);
    check("press_code", keycode0, 5);
    check("press_isrep", is_repeat0, 0);
    rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    check("pop_valid", valid0, 0);
    check("strobe_width", keystrobe0, 0);
    keypad0 = '0;
    ticks(12);
    check("press_count", n_stb0, 1);

    // bounce on key 3, then held
    rd_en0 = 1'b1;
    base = n_stb0;
    for (int i = 0; i < 10; i++) begin
      keypad0[3] = ~keypad0[3];
      ticks(2);
    end
    keypad0[3] = 1'b1;
    exp_q.push_back({1'b0, 4'd3});
    ticks(7);
    check("bounce_early", keystrobe0, 0);
    tick();
    check("bounce_strobe", keystrobe0, 1);
    ticks(4);
    check("bounce_count", n_stb0, base + 1);
    keypad0 = '0;
    ticks(12);
    check("release_count", n_stb0, base + 1);

    // keys 9 and 2 together, then 9 released
    base = n_stb0;
    keypad0 = (13'd1 << 9) | (13'd1 << 2);
    exp_q.push_back({1'b0, 4'd2});
    ticks(12);
    check("multi_count", n_stb0, base + 1);
    keypad0 = 13'd1 << 2;
    ticks(12);
    check("multi_release", n_stb0, base + 1);
    keypad0 = '0;
    ticks(12);
    check("multi_drained", exp_q.size(), 0);
    rd_en0 = 1'b0;

    // auto-repeat on dut1
    keypad1 = 13'd1 << 7;
    m = cyc;
    exp1_q.push_back({1'b0, 4'd7});
    exp_t_q.push_back(m + 8);
    for (int i = 0; i < 5; i++) begin
      exp1_q.push_back({1'b1, 4'd7});
      exp_t_q.push_back(m + 18 + 4 * i);
    end
    ticks(29);
    keypad1 = '0;
    ticks(20);
    check("rpt_count", n_stb1, 6);
    check("rpt_drained", exp1_q.size(), 0);
    check("rpt_times_left", exp_t_q.size(), 0);

    // FIFO fill, full-with-pop, drop, overflow clear priority
    base = n_stb0;
    press0(1, 1);
    press0(4, 1);
    press0(6, 1);
    press0(8, 1);
    check("full_valid", valid0, 1);
    check("full_ovf", overflow0, 0);
    keypad0 = 13'd1 << 10;
    exp_q.push_back({1'b0, 4'd10});
    ticks(7);
    rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    check("fullpop_strobe", keystrobe0, 1);
    check("fullpop_ovf", overflow0, 0);
    ticks(3);
    press0(11, 0);
    check("drop_ovf", overflow0, 1);
    ovf_clr0 = 1'b1;
    tick();
    ovf_clr0 = 1'b0;
    check("ovf_clr", overflow0, 0);
    keypad0 = 13'd1 << 12;
    ticks(7);
    ovf_clr0 = 1'b1;
    tick();
    check("drop_strobe", keystrobe0, 1);
    check("drop_beats_clr", overflow0, 1);
    ovf_clr0 = 1'b0;
    ticks(3);
    keypad0 = '0;
    ticks(12);
    check("fifo_strobes", n_stb0, base + 7);
    rd_en0 = 1'b1;
    ticks(6);
    rd_en0 = 1'b0;
    check("drain_valid", valid0, 0);
    check("drain_queue", exp_q.size(), 0);
    check("ovf_sticky", overflow0, 1);

    // reset with three entries queued and a key held
    press0(1, 1);
    press0(2, 1);
    press0(3, 1);
    check("prerst_valid", valid0, 1);
    nrst = 1'b0;
    #1;
    check("rst_mid_valid", valid0, 0);
    check("rst_mid_ovf", overflow0, 0);
    check("rst_mid_code", keycode0, 0);
    exp_q.delete();
    ticks(2);
    nrst = 1'b1;
    base = n_stb0;
    exp_q.push_back({1'b0, 4'd3});
    ticks(12);
    check("postrst_count", n_stb0, base + 1);
    rd_en0 = 1'b1;
    ticks(3);
    check("postrst_valid", valid0, 0);
    check("postrst_queue", exp_q.size(), 0);
    keypad0 = '0;
    rd_en0 = 1'b0;
    ticks(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 Parameter NKEYS, default 13: number of pushbutton inputs, 1..32.
REQ-002 Parameter CODEW, default 4: keycode width, SHALL satisfy 2**CODEW >= NKEYS.
REQ-003 Parameter DB_CYCLES, default 4: consecutive stable cycles required for debounce, >= 1.
REQ-004 Parameter FIFO_DEPTH, default 4: event FIFO entries, a power of two, >= 2.
REQ-005 Parameter RPT_DELAY, default 0: hold cycles before the first auto-repeat; 0 disables repeat.
REQ-006 Parameter RPT_RATE, default 8: cycles between subsequent repeats, >= 1.
REQ-007 clk  input  1: single system clock; all state updates on the rising edge.
REQ-008 nrst  input  1: asynchronous active-low reset.
REQ-009 keypad  input  NKEYS: raw asynchronous pushbuttons, active high.
REQ-010 rd_en  input  1: pop request for the FIFO head.
REQ-011 ovf_clr  input  1: clears the overflow flag.
REQ-012 keycode  output  CODEW: key index at the FIFO head; 0 when empty.
REQ-013 is_repeat  output  1: head entry was generated by auto-repeat.
REQ-014 valid  output  1: FIFO non-empty.
REQ-015 keystrobe  output  1: one-cycle pulse for each generated event, registered.
REQ-016 overflow  output  1: sticky flag, set when an event is dropped.

Function
REQ-017 keypad SHALL pass through a 2-flop synchronizer before any other logic.
REQ-018 The debouncer SHALL restart its counter whenever the synchronized vector changes, and SHALL copy it into the debounced vector deb after DB_CYCLES consecutive unchanged cycles.
REQ-019 rise = deb_next & ~deb; when rise is nonzero, a press event SHALL be generated with code = lowest set index of rise.
REQ-020 With the keypad stable and the FIFO not full, keystrobe and the write SHALL occur on edge N+3+DB_CYCLES, where edge N is the first edge that samples the new value.
REQ-021 Key releases SHALL generate no event.
REQ-022 Rising bits other than the lowest index in the same update SHALL be discarded.
REQ-023 Repeat FSM states: IDLE, HOLD, RPT.
  - Any press event -> HOLD, tracking that code, count cleared.
  - HOLD: after RPT_DELAY cycles with the tracked key held -> repeat event, -> RPT.
  - RPT: a repeat event every RPT_RATE cycles.
  - Tracked key released in deb -> IDLE.
  - A new press event from HOLD or RPT -> HOLD, retracking the new code.
REQ-024 With RPT_DELAY = 0, the FSM SHALL never leave IDLE.
REQ-025 FIFO entries SHALL be {is_repeat, code}.
  - Push on event when not full.
  - Pop on rd_en & valid.
  - Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Full FIFO with event and pop in the same cycle: both SHALL occur, the event is stored, overflow is unchanged.
REQ-027 Full FIFO with event and no pop: the event SHALL be dropped, overflow set, and keystrobe still pulsed.
REQ-028 rd_en while empty SHALL be ignored; there is no bypass path, so valid rises the cycle after a push into an empty FIFO (the same cycle keystrobe is high).
REQ-029 ovf_clr SHALL clear overflow; a simultaneous drop SHALL take priority and leave overflow set.
REQ-030 keycode and is_repeat SHALL be combinational reads of the head entry, forced to 0 when empty.

Reset
REQ-031 nrst low SHALL immediately clear the synchronizer, deb, debounce counter, FSM (-> IDLE), FIFO pointers and count, overflow, and keystrobe; outputs read 0.
REQ-032 Reset asserted mid-debounce or mid-repeat SHALL discard all pending events.
REQ-033 A key still held at reset release SHALL produce exactly one press event after debounce.

Verification
REQ-034 Defaults: keypad = 13'h0020 held -> keystrobe pulses once at edge N+7; keycode = 5, valid = 1, is_repeat = 0; rd_en for one cycle -> valid = 0.
REQ-035 Bounce: keypad bit 3 toggles every 2 cycles for 20 cycles, then held -> exactly one event, code 3, timed from the last toggle.
REQ-036 Keys 9 and 2 rise in the same cycle -> one event, code 2; key 9 then released -> no event.
REQ-037 RPT_DELAY = 10, RPT_RATE = 4: key 7 held for 30 cycles after debounce -> events at hold cycles 0, 10, 14, 18, 22, 26; first has is_repeat = 0, the rest 1.
REQ-038 FIFO_DEPTH = 4, no reads, 5 distinct presses -> first 4 codes stored in order, overflow = 1; ovf_clr -> 0; pops return codes in order, then valid = 0.
REQ-039 nrst pulsed low while a key is held with 3 entries queued -> valid = 0, overflow = 0 immediately; after release of nrst, one new event for the held key.
